rv_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath. It decodes the instruction register and sequences fetch, decode, execute, memory and write-back over several cycles. It drives every datapath enable and mux select, including the immediate-format select consumed by `immgen`, and runs a request/acknowledge handshake with the unified memory port. It also counts retired instructions and traps on illegal opcodes.

---
 rtl/rv_ctrl_pkg.sv | 65 ++++++
 rtl/rv_opdecode.sv | 36 +++
 rtl/rv_mc_ctrl.sv | 151 +++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle datapath.
// Holds the opcode constants, FSM state encoding, datapath mux-select
// encodings and the instruction-class type used by the control sequencer,
// immgen and the datapath.
package rv_ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 3;

  // Major opcodes (inst[6:0])
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // Sequencer states
  localparam logic [STATE_W-1:0] ST_RST    = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd4;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd5;
  localparam logic [STATE_W-1:0] ST_TRAP   = 3'd6;

  // Immediate formats consumed by immgen
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // Next-PC source
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // Register-file write-back source
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // ALU operation class
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_FUNC = 2'd1;
  localparam logic [1:0] ALU_BR   = 2'd2;

  // Instruction class; OP, OP-IMM and AUIPC share the ALU write-back path
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_LUI    = 3'd6
  } inst_cls_e;

endpackage

// File: rtl/rv_opdecode.sv
// Combinational opcode decoder.
// Ports: opcode (inst[6:0]) in; cls, imm_sel, alu_a_sel, alu_b_sel and
// illegal out. Illegal opcodes decode to NONE with both operand selects 0.
module rv_opdecode
  import rv_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output inst_cls_e        cls,
  output logic [2:0]       imm_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             illegal
);

  always_comb begin
    cls       = CLS_ALU;
    imm_sel   = IMM_NONE;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LOAD:   begin cls = CLS_LOAD;   imm_sel = IMM_I; alu_b_sel = 1'b1; end
      OPC_OP_IMM: begin cls = CLS_ALU;    imm_sel = IMM_I; alu_b_sel = 1'b1; end
      OPC_STORE:  begin cls = CLS_STORE;  imm_sel = IMM_S; alu_b_sel = 1'b1; end
      OPC_BRANCH: begin cls = CLS_BRANCH; imm_sel = IMM_B;                   end
      OPC_AUIPC:  begin cls = CLS_ALU;    imm_sel = IMM_U; alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1; end
      OPC_LUI:    begin cls = CLS_LUI;    imm_sel = IMM_U; alu_b_sel = 1'b1; end
      OPC_JALR:   begin cls = CLS_JALR;   imm_sel = IMM_I; alu_b_sel = 1'b1; end
      OPC_JAL:    begin cls = CLS_JAL;    imm_sel = IMM_J; alu_b_sel = 1'b1; end
      OPC_OP:     begin cls = CLS_ALU;                                       end
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and mux
// selects combinationally from the current state, opcode, mem_ack and
// br_taken, handshakes with the unified memory port, counts retired
// instructions (PC updates) and parks in TRAP on an illegal opcode.
// Ports: clk, rst_n, inst, br_taken, mem_ack in; mem_req, mem_we, ir_we,
// pc_we, pc_sel, imm_sel, alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel,
// state, trap, instret out.
module rv_mc_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  input  logic                 br_taken,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [2:0]           imm_sel,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic [1:0]           alu_op,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic [STATE_W-1:0]   state,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  inst_cls_e  dec_cls;
  logic [2:0] dec_imm_sel;
  logic       dec_a_sel;
  logic       dec_b_sel;
  logic       dec_illegal;

  // Only the major opcode steers sequencing; the rest belongs to the datapath
  logic unused_inst;
  assign unused_inst = ^inst[31:OPC_W];

  rv_opdecode u_opdecode (
    .opcode    (inst[OPC_W-1:0]),
    .cls       (dec_cls),
    .imm_sel   (dec_imm_sel),
    .alu_a_sel (dec_a_sel),
    .alu_b_sel (dec_b_sel),
    .illegal   (dec_illegal)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and control-output decode
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    imm_sel   = IMM_NONE;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    trap      = 1'b0;

    // Operand/immediate selects stay stable from DECODE through WB
    if (state_q == ST_DECODE || state_q == ST_EXEC ||
        state_q == ST_MEM    || state_q == ST_WB) begin
      imm_sel   = dec_imm_sel;
      alu_a_sel = dec_a_sel;
      alu_b_sel = dec_b_sel;
    end

    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = dec_illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (dec_cls)
          CLS_BRANCH: begin
            alu_op  = ALU_BR;
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op  = ALU_ADD;
            state_d = ST_MEM;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec_cls == CLS_STORE);
        if (mem_ack) begin
          if (dec_cls == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (dec_cls)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_LUI:  wb_sel = WB_IMM;
          CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_IMM; end
          CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU; end
          default:  wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_RST;
    endcase

    instret_d = pc_we ? instret_q + INSTRET_W'(1) : instret_q;
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Scoreboard bench for rv_mc_ctrl: the stimulus process walks each
// instruction through a per-instruction timeline model and queues the
// expected outputs for every cycle; a negedge monitor compares them.
module tb_rv_mc_ctrl;

  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   inst_r = '0;
  logic          br_taken = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, ir_we, pc_we, alu_a_sel, alu_b_sel;
  logic          rf_we, trap;
  logic [1:0]    pc_sel, alu_op, wb_sel;
  logic [2:0]    imm_sel, state;
  logic [IW-1:0] instret;

  typedef struct packed {
    logic [2:0]    state;
    logic          mem_req, mem_we, ir_we, pc_we;
    logic [1:0]    pc_sel;
    logic [2:0]    imm_sel;
    logic          a_sel, b_sel;
    logic [1:0]    alu_op;
    logic          rf_we;
    logic [1:0]    wb_sel;
    logic          trap;
    logic [IW-1:0] instret;
  } obs_t;

  // k: 0 illegal,1 OP,2 OP-IMM,3 AUIPC,4 LUI,5 LOAD,6 STORE,7 BRANCH,8 JAL,9 JALR
  typedef struct packed {
    logic [3:0] k;
    logic [2:0] imm;
    logic       a, b;
  } info_t;

  obs_t       expq[$];
  string      tagq[$];
  obs_t       got;
  logic [IW-1:0] cnt = '0;
  int         checks = 0;
  int         fails = 0;

  rv_mc_ctrl #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst_r), .br_taken(br_taken),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  assign got = {state, mem_req, mem_we, ir_we, pc_we, pc_sel, imm_sel,
                alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, trap, instret};

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      obs_t  e;
      string t;
      e = expq.pop_front();
      t = tagq.pop_front();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s: t=%0t got=%h exp=%h (state %0d vs %0d, instret %0d vs %0d)",
                 t, $time, got, e, got.state, e.state, got.instret, e.instret);
      end
    end
  end

  function automatic info_t kind(input logic [6:0] op);
    info_t r;
    r = '0;
    case (op)
      7'b0110011: r = '{k: 4'd1, imm: 3'd0, a: 1'b0, b: 1'b0};
      7'b0010011: r = '{k: 4'd2, imm: 3'd1, a: 1'b0, b: 1'b1};
      7'b0010111: r = '{k: 4'd3, imm: 3'd4, a: 1'b1, b: 1'b1};
      7'b0110111: r = '{k: 4'd4, imm: 3'd4, a: 1'b0, b: 1'b1};
      7'b0000011: r = '{k: 4'd5, imm: 3'd1, a: 1'b0, b: 1'b1};
      7'b0100011: r = '{k: 4'd6, imm: 3'd2, a: 1'b0, b: 1'b1};
      7'b1100011: r = '{k: 4'd7, imm: 3'd3, a: 1'b0, b: 1'b0};
      7'b1101111: r = '{k: 4'd8, imm: 3'd5, a: 1'b0, b: 1'b1};
      7'b1100111: r = '{k: 4'd9, imm: 3'd1, a: 1'b0, b: 1'b1};
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    o.instret = cnt;
    return o;
  endfunction

  function automatic obs_t with_dec(input obs_t e, input info_t k);
    obs_t o;
    o = e;
    o.imm_sel = k.imm;
    o.a_sel = k.a;
    o.b_sel = k.b;
    return o;
  endfunction

  // One clock: drive inputs, queue expectation, advance past the edge
  task automatic cyc(input logic rst, input logic ack, input logic br,
                     input obs_t e, input string tag);
    rst_n = !rst;
    mem_ack = ack;
    br_taken = br;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    if (!rst && e.pc_we) cnt = cnt + 1'b1;
  endtask

  task automatic do_reset(input int n);
    cnt = '0;
    for (int i = 0; i < n; i++) cyc(1'b1, rb(), rb(), base(3'd0), "reset");
    cyc(1'b0, rb(), rb(), base(3'd0), "rst_release");
  endtask

  task automatic run_inst(input logic [31:0] ins, input int fw, input int mw,
                          input logic br, input logic abort);
    info_t k;
    obs_t  e;
    k = kind(ins[6:0]);
    for (int i = 0; i < fw; i++) begin
      e = base(3'd1); e.mem_req = 1'b1;
      cyc(1'b0, 1'b0, rb(), e, "fetch_wait");
    end
    e = base(3'd1); e.mem_req = 1'b1; e.ir_we = 1'b1;
    cyc(1'b0, 1'b1, rb(), e, "fetch_ack");
    inst_r = ins;
    e = with_dec(base(3'd2), k);
    cyc(1'b0, rb(), rb(), e, "decode");
    if (k.k == 4'd0) begin
      for (int i = 0; i < 3; i++) begin
        e = base(3'd6); e.trap = 1'b1;
        cyc(1'b0, rb(), rb(), e, "trap");
      end
      do_reset(2);
      return;
    end
    e = with_dec(base(3'd3), k);
    if (k.k == 4'd7) begin
      e.alu_op = 2'd2; e.pc_we = 1'b1; e.pc_sel = br ? 2'd1 : 2'd0;
      cyc(1'b0, rb(), br, e, "exec_branch");
      return;
    end
    cyc(1'b0, rb(), rb(), e, "exec");
    if (k.k == 4'd5 || k.k == 4'd6) begin
      for (int i = 0; i < mw; i++) begin
        if (abort && i == mw / 2) begin
          do_reset(1);
          return;
        end
        e = with_dec(base(3'd4), k); e.mem_req = 1'b1; e.mem_we = (k.k == 4'd6);
        cyc(1'b0, 1'b0, rb(), e, "mem_wait");
      end
      e = with_dec(base(3'd4), k); e.mem_req = 1'b1; e.mem_we = (k.k == 4'd6);
      e.pc_we = (k.k == 4'd6);
      cyc(1'b0, 1'b1, rb(), e, "mem_ack");
      if (k.k == 4'd6) return;
    end
    e = with_dec(base(3'd5), k); e.rf_we = 1'b1; e.pc_we = 1'b1;
    case (k.k)
      4'd5:    e.wb_sel = 2'd1;
      4'd4:    e.wb_sel = 2'd3;
      4'd8:    begin e.wb_sel = 2'd2; e.pc_sel = 2'd1; end
      4'd9:    begin e.wb_sel = 2'd2; e.pc_sel = 2'd2; end
      default: e.wb_sel = 2'd0;
    endcase
    cyc(1'b0, rb(), rb(), e, "wb");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] r;
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b0010111,
            7'b0110111, 7'b1100111, 7'b1101111, 7'b0110011};
    @(posedge clk);
    #1;
    do_reset(2);
    run_inst(32'hf8010113, 0, 0, 1'b0, 1'b0);  // addi
    run_inst(32'h0187a783, 0, 3, 1'b0, 1'b0);  // lw, 3 wait cycles
    run_inst(32'h00f71a63, 0, 0, 1'b1, 1'b0);  // bne taken
    run_inst(32'hd2e7d8e3, 0, 0, 1'b0, 1'b0);  // bge not taken
    run_inst(32'h010000ef, 1, 0, 1'b0, 1'b0);  // jal
    run_inst(32'h00008067, 0, 0, 1'b0, 1'b0);  // jalr
    run_inst(32'h06112e23, 0, 0, 1'b0, 1'b0);  // sw
    run_inst(32'h00e787b3, 0, 0, 1'b0, 1'b0);  // add
    run_inst(32'h00000000, 0, 0, 1'b0, 1'b0);  // illegal -> TRAP
    run_inst(32'h0187a783, 0, 4, 1'b0, 1'b1);  // reset mid-MEM wait
    run_inst(32'h06112e23, 2, 2, 1'b0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      r = $urandom();
      if ($urandom_range(0, 24) == 0) begin
        ins = r;
        while (kind(ins[6:0]).k != 4'd0) ins = $urandom();
      end else begin
        ins = {r[31:7], ops[$urandom_range(0, 8)]};
      end
      run_inst(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb(),
               ($urandom_range(0, 19) == 0));
    end
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
